// File: rtl/magnitude_compare_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package magnitude_compare_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [1:0] cmp_t;

  localparam cmp_t CMP_LT = 2'd0;
  localparam cmp_t CMP_EQ = 2'd1;
  localparam cmp_t CMP_GT = 2'd2;

endpackage

// File: rtl/magnitude_compare_serial_cmp_digit.sv
// Unsigned compare of one DIGIT-bit slice pair.
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  // Both flags low means the slices are equal.
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/magnitude_compare_serial.sv
// MSB-first digit-serial magnitude comparator with early exit on first differing digit.
module magnitude_compare_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  import magnitude_compare_pkg::*;

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("magnitude_compare_serial: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              busy_d, done_d, gt_d, eq_d, lt_d;
  logic [WIDTH-1:0]  flip;
  logic [DIGIT-1:0]  a_dig, b_dig;
  logic              dig_gt, dig_lt;
  logic              decided;
  cmp_t              code;

  // Signed operands become offset-binary by inverting the MSB, so one unsigned path serves both modes.
  always_comb begin
    flip            = '0;
    flip[WIDTH-1]   = signed_mode;
  end

  // Select the digit currently under comparison.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
    .a  (a_dig),
    .b  (b_dig),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    gt_d    = gt;
    eq_d    = eq;
    lt_d    = lt;
    decided = 1'b0;
    code    = CMP_EQ;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a ^ flip;
          b_d     = b ^ flip;
          idx_d   = IDXW'(NDIG - 1);
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
        end
      end
      RUN: begin
        if (dig_gt) begin
          decided = 1'b1;
          code    = CMP_GT;
        end else if (dig_lt) begin
          decided = 1'b1;
          code    = CMP_LT;
        end else if (idx_q == '0) begin
          decided = 1'b1;
          code    = CMP_EQ;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
        if (decided) begin
          state_d = IDLE;
          done_d  = 1'b1;
          gt_d    = (code == CMP_GT);
          eq_d    = (code == CMP_EQ);
          lt_d    = (code == CMP_LT);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      gt      <= gt_d;
      eq      <= eq_d;
      lt      <= lt_d;
    end
  end

endmodule

// File: tb/tb_magnitude_compare_serial.sv
// Bench for magnitude_compare_serial: 16/4 directed cases plus exhaustive 4/1 sweep.
module tb_magnitude_compare_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, gt16, eq16, lt16;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, gt4, eq4, lt4;

  int n_cmp = 0;
  int n_bad = 0;

  magnitude_compare_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .gt(gt16), .eq(eq16), .lt(lt16)
  );

  magnitude_compare_serial #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden result {gt,eq,lt} from integer values of w-bit operands.
  function automatic logic [2:0] gold(input logic [15:0] x, input logic [15:0] y,
                                      input logic sm, input int w);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (sm && x[w-1]) sx = sx - (longint'(1) << w);
    if (sm && y[w-1]) sy = sy - (longint'(1) << w);
    return {sx > sy, sx == sy, sx < sy};
  endfunction

  // Cycles to decision: 1 + count of leading equal digits (digit 0 never adds).
  function automatic int lat(input logic [15:0] x, input logic [15:0] y, input int w, input int d);
    int k;
    logic [15:0] m;
    k = 1;
    m = 16'((32'd1 << d) - 32'd1);
    for (int i = w / d - 1; i > 0; i--) begin
      if (((x >> (i * d)) & m) == ((y >> (i * d)) & m)) k++;
      else break;
    end
    return k;
  endfunction

  // Transaction-level model of the 16-bit instance.
  logic       m16_busy, m16_done;
  logic [2:0] m16_res, m16_out;
  int         m16_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16_busy <= 1'b0; m16_done <= 1'b0; m16_res <= '0; m16_out <= '0; m16_cnt <= 0;
    end else begin
      m16_done <= 1'b0;
      if (!m16_busy) begin
        if (start16) begin
          m16_busy <= 1'b1;
          m16_cnt  <= lat(a16, b16, 16, 4);
          m16_res  <= gold(a16, b16, sm16, 16);
          m16_out  <= '0;
        end
      end else if (m16_cnt <= 1) begin
        m16_busy <= 1'b0; m16_done <= 1'b1; m16_out <= m16_res;
      end else begin
        m16_cnt <= m16_cnt - 1;
      end
    end
  end

  // Transaction-level model of the 4-bit instance.
  logic       m4_busy, m4_done;
  logic [2:0] m4_res, m4_out;
  int         m4_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_busy <= 1'b0; m4_done <= 1'b0; m4_res <= '0; m4_out <= '0; m4_cnt <= 0;
    end else begin
      m4_done <= 1'b0;
      if (!m4_busy) begin
        if (start4) begin
          m4_busy <= 1'b1;
          m4_cnt  <= lat({12'b0, a4}, {12'b0, b4}, 4, 1);
          m4_res  <= gold({12'b0, a4}, {12'b0, b4}, sm4, 4);
          m4_out  <= '0;
        end
      end else if (m4_cnt <= 1) begin
        m4_busy <= 1'b0; m4_done <= 1'b1; m4_out <= m4_res;
      end else begin
        m4_cnt <= m4_cnt - 1;
      end
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    chk("cycle16", {busy16, done16, gt16, eq16, lt16}, {m16_busy, m16_done, m16_out});
    chk("cycle4",  {busy4,  done4,  gt4,  eq4,  lt4},  {m4_busy,  m4_done,  m4_out});
  end

  // Wait for done16; cycle index i0 is the first negedge sampled.
  task automatic wait_done16(input int i0, output int cyc, output logic [2:0] r);
    cyc = -1;
    r   = '0;
    for (int i = i0; i < i0 + 20; i++) begin
      @(negedge clk);
      if (done16) begin
        cyc = i;
        r   = {gt16, eq16, lt16};
        break;
      end
    end
  endtask

  task automatic txn16(input logic [15:0] ta, input logic [15:0] tb, input logic sm,
                       output int cyc, output logic [2:0] r);
    @(posedge clk); #1;
    a16 = ta; b16 = tb; sm16 = sm; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    wait_done16(0, cyc, r);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, seen;
    logic [2:0] r1, r2;

    // Reset values.
    #12;
    chk("reset_outputs16", {busy16, done16, gt16, eq16, lt16}, 5'b0);
    chk("reset_outputs4",  {busy4,  done4,  gt4,  eq4,  lt4},  5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    txn16(16'h1234, 16'h1233, 1'b0, c1, r1);
    chk("u1234_gt_res", r1, 3'b100);
    chk("u1234_gt_lat", c1, 4);

    txn16(16'h8000, 16'h7FFF, 1'b0, c1, r1);
    chk("u8000_res", r1, 3'b100);
    chk("u8000_lat", c1, 1);

    txn16(16'h8000, 16'h7FFF, 1'b1, c1, r1);
    chk("s8000_res", r1, 3'b001);
    chk("s8000_lat", c1, 1);

    txn16(16'hBEEF, 16'hBEEF, 1'b0, c1, r1);
    chk("beef_eq_res", r1, 3'b010);
    chk("beef_eq_lat", c1, 4);

    // Start held high: second capture lands in the done cycle.
    @(posedge clk); #1;
    a16 = 16'hBEEF; b16 = 16'hBEEF; sm16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    wait_done16(0, c1, r1);
    wait_done16(c1 + 1, c2, r2);
    start16 = 1'b0;
    chk("b2b_first_lat", c1, 4);
    chk("b2b_first_res", r1, 3'b010);
    chk("b2b_gap", c2 - c1, 5);
    chk("b2b_second_res", r2, 3'b010);

    // Start while busy is ignored.
    @(posedge clk); #1;
    a16 = 16'h1200; b16 = 16'h1234; sm16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'h0000; sm16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    wait_done16(2, c1, r1);
    chk("busy_ignore_res", r1, 3'b001);
    chk("busy_ignore_lat", c1, 3);

    // Reset mid-compare aborts with no done pulse.
    @(posedge clk); #1;
    a16 = 16'hBEEF; b16 = 16'hBEEF; sm16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("busy_before_abort", busy16, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy16, done16, gt16, eq16, lt16}, 5'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done16) seen++;
    end
    chk("no_done_after_abort", seen, 0);

    // Exhaustive 4-bit, one bit per cycle, both modes.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          @(posedge clk); #1;
          a4 = 4'(x); b4 = 4'(y); sm4 = s[0]; start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          c1 = -1;
          r1 = '0;
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) begin
              c1 = i;
              r1 = {gt4, eq4, lt4};
              break;
            end
          end
          chk("sweep4_res", r1, gold(16'(x), 16'(y), s[0], 4));
          chk("sweep4_lat", c1, lat(16'(x), 16'(y), 4, 1));
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
